// File: rtl/ter_pkg.sv
// Balanced-ternary helpers on the {sign, nonzero} 2-bit code used across the
// poly-lift path: 00 = 0, 01 = 1, 11 = -1. The code 10 is never produced.
package ter_pkg;

  localparam logic [1:0] TER_ZERO = 2'b00;
  localparam logic [1:0] TER_ONE  = 2'b01;
  localparam logic [1:0] TER_MONE = 2'b11;

  function automatic logic [1:0] ter_sanitize(input logic [1:0] a);
    return (a == 2'b10) ? TER_ZERO : a;
  endfunction

  function automatic logic [1:0] ter_neg(input logic [1:0] a);
    case (a)
      TER_ONE:  return TER_MONE;
      TER_MONE: return TER_ONE;
      default:  return TER_ZERO;
    endcase
  endfunction

  // Like terms double, and in Z3 doubling is the same as negation.
  function automatic logic [1:0] ter_add(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x, y;
    x = ter_sanitize(a);
    y = ter_sanitize(b);
    if (x == TER_ZERO) return y;
    if (y == TER_ZERO) return x;
    if (x == y)        return ter_neg(x);
    return TER_ZERO;
  endfunction

endpackage

// File: rtl/ter_prefix_lanes.sv
// Combinational mod-3 prefix chain across one beat of lanes.
module ter_prefix_lanes
  import ter_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [1:0]             cin,
  input  logic [LANES-1:0][1:0]  lane_in,
  output logic [LANES-1:0][1:0]  lane_sum,
  output logic [1:0]             cout
);

  logic [1:0] chain [LANES+1];

  assign chain[0] = cin;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign chain[j+1]  = ter_add(chain[j], lane_in[j]);
    assign lane_sum[j] = chain[j+1];
  end

  assign cout = chain[LANES];

endmodule

// File: rtl/ter_prefix_stream.sv
// Streaming mod-3 running sum over frames of N ternary coefficients, LANES per
// beat, with per-frame seed/sign selection and a single registered output stage.
module ter_prefix_stream
  import ter_pkg::*;
#(
  parameter int LANES = 4,
  parameter int N     = 701
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           seed,
  input  logic                 mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*LANES-1:0]   out_data,
  output logic                 out_last,
  output logic                 busy
);

  localparam int BEATS  = (N + LANES - 1) / LANES;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int CW     = (BEAT_W < 1) ? 1 : BEAT_W;
  localparam int TAIL   = N - (BEATS - 1) * LANES;  // live lanes on the final beat

  logic [CW-1:0]          beat_cnt;
  logic [1:0]             acc;
  logic                   mode_q;
  logic                   first, last, accept, eff_mode;
  logic [1:0]             cin, cout;
  logic [LANES-1:0][1:0]  lane_in, lane_sum, lane_out;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (beat_cnt == '0);
  assign last     = (beat_cnt == CW'(BEATS - 1));
  assign busy     = !first;
  assign cin      = first ? ter_sanitize(seed) : acc;
  assign eff_mode = first ? mode : mode_q;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    localparam bit PAD = (j >= TAIL);
    logic kill;
    assign kill        = PAD && last;
    assign lane_in[j]  = kill ? TER_ZERO : ter_sanitize(in_data[2*j +: 2]);
    assign lane_out[j] = kill ? TER_ZERO :
                         (eff_mode ? ter_neg(lane_sum[j]) : lane_sum[j]);
  end

  ter_prefix_lanes #(.LANES(LANES)) u_lanes (
    .cin      (cin),
    .lane_in  (lane_in),
    .lane_sum (lane_sum),
    .cout     (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      beat_cnt  <= '0;
      acc       <= TER_ZERO;
      mode_q    <= 1'b0;
    end else begin
      if (in_ready) out_valid <= in_valid;
      if (accept) begin
        out_data <= lane_out;
        out_last <= last;
        if (first) mode_q <= mode;
        // Clearing on the last beat lets the next frame start back-to-back.
        if (last) begin
          beat_cnt <= '0;
          acc      <= TER_ZERO;
        end else begin
          beat_cnt <= beat_cnt + CW'(1);
          acc      <= cout;
        end
      end
    end
  end

endmodule

// File: doc/ter_prefix_stream.md
Name: ter_prefix_stream

Overview:
- Streaming mod-3 running-sum engine for ternary polynomial coefficients.
- Processes LANES coefficients per beat over frames of N coefficients; accumulator carries across beats.
- Computes division by (x-1) over Z3 and the phi1-inverse sequence generation needed by the poly-lift path.
- Generalises the fixed two-step ternary state recurrence to a parametrised lane count, framing, seeding, sign mode and a valid/ready handshake.

Parameters:
- LANES, 4, coefficients per beat (1..16).
- N, 701, coefficients per frame (N >= 1).
- BEAT_W, $clog2((N+LANES-1)/LANES), beat-counter width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- seed  in  2  ternary initial accumulator value; sampled on the first accepted beat of a frame.
- mode  in  1  0 = output prefix sums; 1 = output negated prefix sums; sampled with seed.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid and in_ready.
- in_data  in  2*LANES  lane j in bits [2j+1:2j]; lane 0 is the lowest-index coefficient.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  2*LANES  prefix results, same lane order.
- out_last  out  1  marks the final beat of a frame.
- busy  out  1  high while a frame is partially consumed (beat counter != 0).

Behaviour:
- Ternary encoding is {sign, nonzero}:
  - 2'b00 = 0, 2'b01 = 1, 2'b11 = 2 (-1).
  - 2'b10 is illegal on input and is treated as 0.
  - Outputs never carry 2'b10.
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, accumulator=0, beat counter=0, stored mode=0. in_ready=1 out of reset.
- Pipeline: one output register stage.
  - in_ready = !out_valid | out_ready, combinational from the register state and out_ready only.
  - Accepted beat b produces its output in the following cycle (latency 1). Full throughput with out_ready held high.
- Per accepted beat, with acc = running sum and c_j = lane coefficient:
  - r_j = acc + c_0 + ... + c_j (mod 3).
  - out lane j = r_j if stored mode=0, or -r_j if mode=1 (negation swaps 01<->11; 00 unchanged).
  - acc <= r_{LANES-1} after the beat.
- Frame start (beat counter == 0): the effective acc for that beat is seed, not the register; mode is latched for the whole frame. seed/mode are ignored on other beats.
- Final beat (counter == ceil(N/LANES)-1):
  - Lanes with global index >= N are masked to input 0, and their output lanes are forced to 00.
  - out_last=1 on that output beat.
  - Counter returns to 0 and acc clears to 0, so the next frame may begin on the very next cycle.
- Backpressure: while out_valid & !out_ready, out_data, out_last and out_valid hold stable and no input is accepted.
- in_valid low: no state change. Bubbles mid-frame are legal and must not alter acc.
- rst mid-frame: the partial frame is discarded, the output register is cleared (a pending beat is dropped), and the next accepted beat is treated as a frame start.
- Arithmetic uses only 2-bit mod-3 add/neg. There is no binary widening.

Decomposition:
- Package ter_pkg holds:
  - Encoding constants TER_ZERO, TER_ONE, TER_MONE.
  - Functions ter_add(a,b), ter_neg(a), ter_sanitize(a) (maps 10 to 00).
- Sub-module ter_prefix_lanes (parameter LANES): combinational chain that takes the carry-in and lane vector and produces the LANES prefix results plus carry-out.
- The top level holds the beat counter, seed/mode latch, accumulator, tail masking, output register and handshake.

Test Plan:
1. Basic sums (LANES=4, N=6, seed=0, mode=0). Beats [1,1,1,2], [1,0,x,x] -> out [01,11,00,11], then [00,00,00,00] with out_last=1 on the second beat.
2. Negation and seed. Same data, seed=1, mode=1 -> sums [2,0,1,0],[1,1] -> out [01,00,11,00], [11,11,00,00]. mode changed on beat 2 is ignored.
3. Backpressure. out_ready=0 for 3 cycles after beat 1 -> out_data held constant, in_ready=0, beat 2 not consumed. On release, results are identical to scenario 1.
4. Back-to-back frames with in_valid bubbles (LANES=4, N=8, input all 01 across two frames, seed 0 then seed 2).
   - Frame 1 out [01,11,00,01], [11,00,01,11].
   - Frame 2 starts from 2 -> [00,01,11,00], [01,11,00,01].
   - Bubbles do not change results.
5. Illegal code and reset. A lane driven 10 behaves as 0 and no output lane is ever 10. rst asserted mid-frame -> out_valid=0 and busy=0 next cycle; the next beat uses the new seed.
6. Random check: constrained-random beats, LANES in {1,3,4,8}, N in {1,5,701}, random stalls -> compare against a per-coefficient mod-3 reference model.
